// File: rtl/code_ram_loader.sv
// Program memory for processor18 with a byte-stream loader that fills it from address 0
// and holds the processor in reset until the load has finished.
module code_ram_loader #(
    parameter int ADDR_SIZE = 18,
    parameter int WORD_SIZE = 18,
    parameter int MEM_SIZE  = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 load_start,
    input  logic [ADDR_SIZE-1:0] load_count,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_byte,
    input  logic [ADDR_SIZE-1:0] code_addr,
    output logic [WORD_SIZE-1:0] code_word,
    output logic                 processor_reset,
    output logic                 load_done,
    output logic                 load_error,
    output logic [1:0]           state_dbg
);

    // Handshake: a byte transfers on a rising clock edge where in_valid && in_ready;
    // in_ready is registered and high exactly while the loader sits in RECV.

    localparam int BPW = (WORD_SIZE + 7) / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int AW  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_SIZE:0] MEM_LIM   = (ADDR_SIZE + 1)'(MEM_SIZE);
    localparam logic [BCW-1:0]     LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] mem [0:MEM_SIZE-1];
    logic [WORD_SIZE-1:0] shreg;
    logic [BCW-1:0]       byte_cnt;
    logic [ADDR_SIZE-1:0] word_addr;
    logic [ADDR_SIZE-1:0] word_total;
    logic                 too_big;

    assign too_big   = ({1'b0, load_count} > MEM_LIM);
    assign state_dbg = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            in_ready        <= 1'b0;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
            processor_reset <= 1'b1;
            byte_cnt        <= '0;
            word_addr       <= '0;
            word_total      <= '0;
            shreg           <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (load_start) begin
                        load_error <= too_big;
                        word_total <= too_big ? MEM_LIM[ADDR_SIZE-1:0] : load_count;
                        word_addr  <= '0;
                        byte_cnt   <= '0;
                        if (load_count == '0) begin
                            state           <= DONE;
                            in_ready        <= 1'b0;
                            load_done       <= 1'b1;
                            processor_reset <= 1'b0;
                        end else begin
                            state           <= RECV;
                            in_ready        <= 1'b1;
                            load_done       <= 1'b0;
                            processor_reset <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (in_valid && in_ready) begin
                        // Only the low WORD_SIZE bits ever reach memory, so older bytes fall off the top.
                        shreg <= WORD_SIZE'({shreg, in_byte});
                        if (byte_cnt == LAST_BYTE) begin
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            byte_cnt <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                WRITE: begin
                    word_addr <= word_addr + ADDR_SIZE'(1);
                    byte_cnt  <= '0;
                    if ((word_addr + ADDR_SIZE'(1)) == word_total) begin
                        state           <= DONE;
                        load_done       <= 1'b1;
                        processor_reset <= 1'b0;
                    end else begin
                        state    <= RECV;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage has no reset so program contents survive an aborted load.
    always_ff @(posedge clock) begin
        if (state == WRITE) begin
            mem[word_addr[AW-1:0]] <= shreg;
        end
    end

    assign code_word = ({1'b0, code_addr} < MEM_LIM) ? mem[code_addr[AW-1:0]] : '0;

endmodule
